// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and read-modify-write stores against a registered-read word memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of ignoring the low address bits.
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 64,
  localparam int WA    = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [WA+1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [WA-1:0]     mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [WA-1:0]     mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [WA+1:0]       addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                acc_err;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   store_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Unsupported encodings and unsigned stores fault; alignment faults only in the trapping build.
  always_comb begin
    acc_err = 1'b0;
    case (f3_q)
      3'b000, 3'b001, 3'b010: acc_err = 1'b0;
      3'b100, 3'b101:         acc_err = we_q;
      default:                acc_err = 1'b1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q == 3'b010 && addr_q[1:0] != 2'b00))
      acc_err = 1'b1;
`endif
  end

  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_val = '0;
    case (f3_q)
      3'b000:  load_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
      3'b010:  load_val = mem_rdata;
      3'b100:  load_val = {{(DATA_W-8){1'b0}}, byte_sel};
      3'b101:  load_val = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_val = '0;
    endcase
  end

  // Read-modify-write merge: only the addressed lanes take store data.
  always_comb begin
    store_val = mem_rdata;
    case (f3_q[1:0])
      2'b00:   store_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   store_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      2'b10:   store_val = wdata_q;
      default: store_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == RD_WAIT) begin
      rsp_rdata <= (we_q || acc_err) ? '0 : load_val;
      rsp_err   <= acc_err;
    end
  end

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign mem_raddr = (state == IDLE) ? req_addr[WA+1:2] : addr_q[WA+1:2];
  assign mem_waddr = addr_q[WA+1:2];
  assign mem_wdata = store_val;
  assign mem_we    = (state == RD_WAIT) && we_q && !acc_err && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: word memory model, directed cases, then randomized traffic.
// Honours LSU_MISALIGN_TRAP_EN in its reference model.
module tb_load_store_unit;
  localparam int WA   = 6;
  localparam int ROWS = 64;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        we1;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [WA+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_we;
  logic [WA-1:0] mem_waddr, mem_raddr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] mem     [ROWS];
  logic [31:0] ref_mem [ROWS];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          rsp_count = 0;
  int          cyc, we_cnt;
  bit          inflight = 0, seen = 0;

  load_store_unit #(.DATA_W(32), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_raddr];
  always @(negedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finishTest();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  endtask

  // Reference model: plain lane arithmetic on a word array; updates ref_mem for stores.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                                 input logic [31:0] wdata);
    exp_t        e;
    int          idx = int'(addr >> 2);
    int          off = int'(addr & 8'd3);
    int          nbytes;
    logic [63:0] word, mask, val, nv;
    bit          bad;
    word   = 64'(ref_mem[idx]);
    bad    = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && f3 >= 3'd4);
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
    if (off % nbytes != 0) bad = 1;
`endif
    off  = off - (off % nbytes);
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    e.rdata = '0;
    e.err   = bad;
    e.we1   = 1'b0;
    if (!bad) begin
      if (we) begin
        nv = (word & ~(mask << (8 * off))) | ((64'(wdata) & mask) << (8 * off));
        ref_mem[idx] = nv[31:0];
        e.we1 = 1'b1;
      end else begin
        val = (word >> (8 * off)) & mask;
        if (f3 < 3'd4 && val[8*nbytes-1]) val = val | ~mask;
        e.rdata = val[31:0];
      end
    end
    return e;
  endfunction

  // Issues one request at posedge+1 from IDLE and waits for its response handshake.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                               input logic [31:0] wdata, input int delay);
    int base;
    exp_q.push_back(model(we, f3, addr, wdata));
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rsp_ready  = (delay == 0);
    @(posedge clk) #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = 8'($urandom);
    req_wdata  = $urandom;
    base = rsp_count;
    for (int i = 0; i < delay; i++) @(posedge clk) #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && rsp_count == base; i++) @(posedge clk) #1;
    rsp_ready = 1'b0;
    if (rsp_count == base) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL rsp_timeout: got no response expected handshake within 30 cycles");
      finishTest();
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake; tracks latency and write pulses.
  always @(negedge clk) begin
    if (rst) begin
      inflight = 0;
    end else if (inflight) begin
      cyc++;
      if (mem_we) we_cnt++;
      checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          checkOutput("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          checkOutput("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
          if (!seen) begin
            seen = 1;
            checkOutput("latency", 32'(cyc), 32'd2);
          end
          if (rsp_ready) begin
            checkOutput("mem_we_cycles", 32'(we_cnt), 32'(exp_q[0].we1));
            void'(exp_q.pop_front());
            inflight = 0;
            rsp_count++;
          end
        end
      end
    end else if (req_valid && req_ready) begin
      inflight = 1;
      seen     = 0;
      cyc      = 0;
      we_cnt   = 0;
    end else begin
      checkOutput("mem_we_idle", 32'(mem_we), 32'd0);
    end
  end

  initial begin
    #300000;
    n_checks++;
    n_fails++;
    $display("[TB] FAIL watchdog: got no finish expected finish before 300us");
    finishTest();
  end

  initial begin
    for (int i = 0; i < ROWS; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[3]     = 32'h8899AABB;
    ref_mem[3] = 32'h8899AABB;

    @(negedge clk);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk) #1;

    $display("[TB] directed cases");
    applyStimulus(1'b0, 3'b000, 8'h0D, $urandom, 0);
    applyStimulus(1'b1, 3'b001, 8'h0E, 32'h00001234, 0);
    checkOutput("sh_word3", mem[3], 32'h1234AABB);
    applyStimulus(1'b0, 3'b101, 8'h0C, $urandom, 6);
    applyStimulus(1'b0, 3'b011, 8'h10, $urandom, 1);
    applyStimulus(1'b1, 3'b100, 8'h10, 32'h000000FF, 0);
    checkOutput("err_word4", mem[4], ref_mem[4]);
    applyStimulus(1'b0, 3'b010, 8'h0E, $urandom, 0);

    $display("[TB] reset during RD_WAIT");
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 8'h14;
    req_wdata  = 32'hDEADBEEF;
    @(posedge clk) #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    checkOutput("rdw_rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rdw_rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rdw_ready_after", 32'(req_ready), 32'd1);
    checkOutput("rdw_valid_after", 32'(rsp_valid), 32'd0);
    checkOutput("rdw_word5", mem[5], ref_mem[5]);
    @(posedge clk) #1;

    $display("[TB] random traffic");
    for (int n = 0; n < 150; n++)
      applyStimulus(1'($urandom), 3'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 3)));

    for (int i = 0; i < ROWS; i++) checkOutput($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    finishTest();
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, which sets the data word width; only 32 is supported.
REQ-002 SHALL have parameter ROWS, default 64, which sets the memory depth in words; WA = $clog2(ROWS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_we (in, 1; 1 = store), req_funct3 (in, 3; access type) for the request handshake.
REQ-006 SHALL have ports req_addr (in, WA+2; byte address) and req_wdata (in, DATA_W; store data in the low bits).
REQ-007 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_rdata (out, DATA_W; load result, 0 for stores) and rsp_err (out, 1; access fault) for the response handshake.
REQ-008 SHALL have memory-side ports mem_we (out, 1), mem_waddr (out, WA), mem_wdata (out, DATA_W), mem_raddr (out, WA) and mem_rdata (in, DATA_W).
REQ-009 SHALL connect to a word memory that samples mem_raddr at posedge, returns a registered mem_rdata after that edge, and writes on the negedge while mem_we = 1.

Function
REQ-010 SHALL use FSM states IDLE, RD_WAIT and RESP.
REQ-011 SHALL assert req_ready only in IDLE; a request is accepted at a posedge where req_valid && req_ready; IDLE then moves to RD_WAIT.
REQ-012 SHALL latch we, funct3, addr and wdata on acceptance.
REQ-013 SHALL drive mem_raddr = req_addr[WA+1:2] in IDLE and the latched word address otherwise, so mem_rdata is valid throughout RD_WAIT.
REQ-014 SHALL decode funct3 as 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; lanes are little-endian, selected by addr[1:0].
REQ-015 SHALL, for a load in RD_WAIT, extract the lane, sign- or zero-extend it, and register the result into rsp_rdata at the RD_WAIT to RESP edge.
REQ-016 SHALL, for a store in RD_WAIT, assert mem_we for that cycle only, with mem_waddr = latched word address and mem_wdata = mem_rdata with only the target byte/half lanes replaced (read-modify-write); SW replaces the whole word.
REQ-017 SHALL move RD_WAIT to RESP unconditionally.
REQ-018 SHALL hold rsp_valid = 1 in RESP and keep rsp_rdata and rsp_err stable until rsp_ready = 1, then return to IDLE.
REQ-019 SHALL give minimum latency from accept edge to rsp_valid = 1 of 2 cycles, and minimum request spacing of 3 cycles; there is no pipelining.
REQ-020 SHALL treat unsupported funct3 (011, 110, 111; store with funct3[2] = 1) as an error: rsp_err = 1, rsp_rdata = 0, mem_we stays 0.
REQ-021 SHALL keep mem_we = 0 in IDLE and RESP.

Reset
REQ-022 SHALL, while rst = 1, force state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 and req_ready = 0.
REQ-023 SHALL gate mem_we combinationally with !rst, so a reset asserted in RD_WAIT before the negedge suppresses the store; an in-flight response is discarded.
REQ-024 SHALL assert req_ready = 1 in the first cycle after rst falls.

Configuration
REQ-025 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat LH/LHU/SH with addr[0] = 1 and LW/SW with addr[1:0] != 0 as errors (rsp_err = 1, rsp_rdata = 0, no write).
REQ-026 SHALL, with LSU_MISALIGN_TRAP_EN undefined, never fault on misalignment: halfword lane = addr[1], addr[0] ignored; word accesses ignore addr[1:0].

Verification
REQ-027 SHALL cover: word 3 = 0x8899AABB, LB addr 0x0D -> rsp_rdata 0xFFFFFFAA, rsp_err 0, rsp_valid 2 cycles after accept.
REQ-028 SHALL cover: word 3 = 0x8899AABB, SH addr 0x0E wdata 0x00001234 -> word 3 becomes 0x1234AABB; mem_we high exactly one cycle; rsp_rdata 0.
REQ-029 SHALL cover: LHU addr 0x0C on 0x8899AABB with rsp_ready held 0 for 5 cycles -> rsp_valid stays high with 0x0000AABB stable; req_ready low until the handshake completes.
REQ-030 SHALL cover: funct3 011 load, then SB with funct3 100 -> both give rsp_err 1, no mem_we, memory unchanged.
REQ-031 SHALL cover: LW addr 0x0E -> with macro, rsp_err 1; without macro, rsp_err 0 and rsp_rdata = word 3.
REQ-032 SHALL cover: rst pulsed during RD_WAIT of SW 0xDEADBEEF to word 5 -> word 5 unchanged, rsp_valid 0, req_ready 1 the cycle after rst falls.
